// File: rtl/alu_issue_stage.sv
// ALU issue stage: 2-entry operand FIFO feeding a combinational unit,
// with a registered result stage and a wrap-around completion counter.
module alu_issue_stage #(
  parameter int WIDTH = 32,
  parameter int OPW   = 3,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [OPW-1:0]   in_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_res,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic [OPW-1:0]   out_op,
  output logic             out_zero,
  output logic [CNTW-1:0]  done_cnt
);

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [OPW-1:0]   op;
  } ent_t;

  ent_t       mem [2];
  logic       wp;
  logic       rp;
  logic [1:0] cnt;
  logic       push;
  logic       pop;
  logic       hs;

  // Readiness depends only on FIFO occupancy, never on out_ready.
  assign in_ready = (cnt < 2'd2) && rst_n;
  assign push     = in_valid && in_ready;
  assign pop      = (cnt != 2'd0) && (!out_valid || out_ready);
  assign hs       = out_valid && out_ready;

  assign alu_a  = mem[rp].a;
  assign alu_b  = mem[rp].b;
  assign alu_op = mem[rp].op;

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wp] <= '{a: in_a, b: in_b, op: in_op};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wp  <= 1'b0;
      rp  <= 1'b0;
      cnt <= 2'd0;
    end else begin
      if (push) wp <= ~wp;
      if (pop)  rp <= ~rp;
      unique case (1'b1)
        push && !pop: cnt <= cnt + 2'd1;
        !push && pop: cnt <= cnt - 2'd1;
        default:      cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_res   <= '0;
      out_op    <= '0;
      out_zero  <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (pop) begin
      out_valid <= 1'b1;
      out_res   <= alu_res;
      out_op    <= mem[rp].op;
      out_zero  <= (alu_res == '0);
    end else if (hs) begin
      out_valid <= 1'b0;
    end
  end

  // A handshake coinciding with flush still completes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      done_cnt <= '0;
    end else if (hs) begin
      done_cnt <= done_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage with a bench-side AND/OR/XOR/ADD unit.
module tb_alu_issue_stage;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [2:0]  in_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_op;
  logic [31:0] alu_res;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_res;
  logic [2:0]  out_op;
  logic        out_zero;
  logic [15:0] done_cnt;

  typedef struct {
    logic [31:0] res;
    logic [2:0]  op;
    logic        z;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  alu_issue_stage #(.WIDTH(32), .OPW(3), .CNTW(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_res(alu_res),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_op(out_op), .out_zero(out_zero),
    .done_cnt(done_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] alu_f(
    input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a ^ b;
      default: return a + b;
    endcase
  endfunction

  always_comb alu_res = alu_f(alu_a, alu_b, alu_op);

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: handshake seen at negedge completes on the next posedge.
  logic        stall_prev = 1'b0;
  logic [31:0] p_res;
  logic [2:0]  p_op;
  logic        p_z;
  exp_t        e;

  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_prev && out_valid) begin
        chk("hold_res", out_res, p_res);
        chk("hold_op", out_op, p_op);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_out", 1, 0);
        end else begin
          e = q.pop_front();
          chk("sb_res", out_res, e.res);
          chk("sb_op", out_op, e.op);
          chk("sb_zero", out_zero, e.z);
        end
      end
    end
    stall_prev = rst_n && !flush && out_valid && !out_ready;
    p_res = out_res;
    p_op  = out_op;
    p_z   = out_zero;
  end

  task automatic push(input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] op, input logic [31:0] er,
                      input int budget, output bit ok);
    in_a = a;
    in_b = b;
    in_op = op;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (in_ready && !flush) begin
        q.push_back('{res: er, op: op, z: (er == 32'd0)});
        ok = 1'b1;
        @(posedge clk);
        #1;
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (q.size() == 0) begin
        done = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk(name, done, 1);
  endtask

  bit          ok;
  int          t0;
  int          t1;
  logic [31:0] ra;
  logic [31:0] rb;
  logic [2:0]  rop;

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    in_op = '0;
    out_ready = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_done_cnt", done_cnt, 0);
    chk("rst_out_res", out_res, 0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", in_ready, 1);

    // Single AND op, one-edge latency
    push(32'hF0F0F0F0, 32'hFF00FF00, 3'd0, 32'hF000F000, 4, ok);
    chk("single_accept", ok, 1);
    chk("single_lat0", out_valid, 0);
    @(posedge clk);
    #1;
    chk("single_valid", out_valid, 1);
    chk("single_res", out_res, 32'hF000F000);
    chk("single_zero", out_zero, 0);
    @(posedge clk);
    #1;
    chk("single_done", done_cnt, 1);

    // Zero flag
    push(32'h0F0F0F0F, 32'hF0F0F0F0, 3'd0, 32'h0, 4, ok);
    @(posedge clk);
    #1;
    chk("zero_res", out_res, 0);
    chk("zero_flag", out_zero, 1);
    drain("zero_drain", 10);
    chk("zero_done", done_cnt, 2);

    // Backpressure: 1 staged + 2 buffered, 4th refused
    out_ready = 1'b0;
    push(32'h12340000, 32'h00005678, 3'd1, 32'h12345678, 4, ok);
    chk("bp_acc0", ok, 1);
    push(32'hFFFF0000, 32'hFF00FF00, 3'd2, 32'h00FFFF00, 4, ok);
    chk("bp_acc1", ok, 1);
    push(32'hAAAA5555, 32'h5555AAAA, 3'd0, 32'h0, 4, ok);
    chk("bp_acc2", ok, 1);
    chk("bp_full", in_ready, 0);
    push(32'h1, 32'h1, 3'd3, 32'h2, 5, ok);
    chk("bp_refused", ok, 0);
    chk("bp_staged", out_valid, 1);
    out_ready = 1'b1;
    drain("bp_drain", 20);
    chk("bp_done", done_cnt, 5);

    // Streaming 100 back-to-back tuples
    for (int i = 0; i < 100; i++) begin
      ra  = $urandom;
      rb  = $urandom;
      rop = 3'($urandom_range(0, 3));
      push(ra, rb, rop, alu_f(ra, rb, rop), 4, ok);
      if (i == 0) t0 = cyc;
      if (!ok) chk("stream_accept", ok, 1);
    end
    t1 = -1;
    for (int i = 0; i < 20; i++) begin
      if (done_cnt == 16'd105) begin
        t1 = cyc;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk("stream_latency", t1 - t0, 101);
    chk("stream_done", done_cnt, 105);

    // Flush with 1 staged + 2 buffered
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push(32'h11 + i, 32'h22, 3'd1, (32'h11 + i) | 32'h22, 4, ok);
    end
    chk("fl_full", in_ready, 0);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    q.delete();
    chk("fl_valid", out_valid, 0);
    chk("fl_ready", in_ready, 1);
    chk("fl_done", done_cnt, 105);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("fl_no_stale", out_valid, 0);

    // Reset mid-stream
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push(32'h100 + i, 32'h3, 3'd2, (32'h100 + i) ^ 32'h3, 4, ok);
    end
    rst_n = 1'b0;
    #1;
    chk("mrst_ready_low", in_ready, 0);
    repeat (2) @(posedge clk);
    #1;
    q.delete();
    chk("mrst_valid", out_valid, 0);
    chk("mrst_done", done_cnt, 0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("mrst_ready", in_ready, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("mrst_no_stale", out_valid, 0);

    // Counter wrap
    for (int i = 0; i < 65535; i++) begin
      ra = i;
      push(ra, 32'h0000FFFF, 3'd1, ra | 32'h0000FFFF, 4, ok);
      if (!ok) chk("wrap_accept", ok, 1);
    end
    drain("wrap_drain", 20);
    chk("wrap_max", done_cnt, 16'hFFFF);
    push(32'h5, 32'h3, 3'd3, 32'h8, 4, ok);
    drain("wrap_drain2", 20);
    chk("wrap_zero", done_cnt, 16'h0000);

    chk("sb_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Operand issue and result-capture stage placed around the combinational ALU datapath units, such as the 32-bit bitwise AND/OR/XOR units.
- Accepts operand/opcode tuples through a valid/ready handshake and buffers them in a 2-entry FIFO.
- Drives the head entry onto the combinational unit inputs, then registers the returned result with a zero flag into an output stage that has its own valid/ready handshake.
- Keeps a wrap-around count of completed results.

Parameters:
- WIDTH, 32, operand/result width in bits.
- OPW, 3, opcode width; passed through unchanged, never decoded here.
- CNTW, 16, width of the completed-result counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- flush  input  1  synchronous clear of buffered and output-staged entries.
- in_valid  input  1  upstream tuple valid.
- in_ready  output  1  stage can accept a tuple.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_op  input  OPW  opcode.
- alu_a  output  WIDTH  FIFO head operand A to the combinational unit.
- alu_b  output  WIDTH  FIFO head operand B to the combinational unit.
- alu_op  output  OPW  FIFO head opcode to the combinational unit.
- alu_res  input  WIDTH  combinational unit result for alu_a/alu_b/alu_op, same cycle.
- out_valid  output  1  registered result valid.
- out_ready  input  1  downstream accepts the result.
- out_res  output  WIDTH  registered result.
- out_op  output  OPW  opcode of the registered result.
- out_zero  output  1  1 when out_res == 0.
- done_cnt  output  CNTW  count of results accepted downstream.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - FIFO count=0, read/write pointers=0.
  - out_valid=0, out_res=0, out_op=0, out_zero=0, done_cnt=0.
  - in_ready=0 during reset cycles; in_ready=1 from the first cycle after reset deasserts.
  - Reset mid-operation discards all entries; no partial result ever appears.
- in_ready = (count < 2) && rst_n.
  - in_ready is driven from registered state only; there is no combinational path from out_ready to in_ready.
- Push: in_valid && in_ready at an edge writes {in_a, in_b, in_op} to the write pointer; the pointer toggles.
- alu_a/alu_b/alu_op always show the head entry. When count==0 they hold the last head value (don't-care); verification must not check them while count==0.
- Pop/capture condition: count > 0 && (!out_valid || out_ready). At that edge:
  - out_res <= alu_res, out_op <= head op, out_zero <= (alu_res == 0), out_valid <= 1.
  - The read pointer toggles.
- When out_valid && out_ready and no capture occurs (count==0): out_valid <= 0; out_res, out_op and out_zero hold.
- Accepted result: out_valid && out_ready at an edge increments done_cnt. done_cnt wraps from 2^CNTW-1 to 0.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop at count==1: count stays 1.
  - push at count==2 is impossible because in_ready=0.
  - push and pop at count==0 is impossible; a pushed entry is not visible to the head until the next cycle.
- Latency and throughput:
  - A tuple accepted at edge k, with the stage otherwise empty, is captured at edge k+1; out_valid is high from edge k+1.
  - Sustained throughput is 1 result/cycle while out_ready=1.
- Backpressure: while out_valid && !out_ready:
  - out_* hold stable.
  - The FIFO fills to 2, then in_ready=0.
  - No entry is lost or duplicated.
- Ordering: results leave strictly in acceptance order.
- flush=1 at an edge:
  - count=0, pointers=0, out_valid=0.
  - A simultaneous push is dropped.
  - A simultaneous out handshake still counts in done_cnt.
  - done_cnt is otherwise unaffected.
  - rst_n has priority over flush.
- out_valid must not drop without a handshake, except on flush or reset.

Test Plan:
- Single op: after reset, push a=0xF0F0F0F0, b=0xFF00FF00, op=0; the bench returns alu_res=a&b. Required: out_res=0xF000F000 and out_zero=0 one edge after acceptance; done_cnt=1 after handshake.
- Zero flag: push a=0x0F0F0F0F, b=0xF0F0F0F0 with AND model. Required: out_res=0, out_zero=1.
- Backpressure: hold out_ready=0 and push 4 tuples. Required: 3 accepted (1 staged + 2 buffered), then in_ready=0. Release out_ready: results emerge in order, done_cnt=3.
- Streaming: out_ready=1, push 100 back-to-back random tuples. Required: 100 consecutive out_valid cycles after the first one-edge latency, all matching the model; done_cnt=100.
- Flush/reset mid-stream: with 2 buffered and 1 staged, assert flush for 1 cycle. Required: out_valid=0 and in_ready=1 next cycle, with no stale output. Repeat with rst_n=0: done_cnt=0.
- Counter wrap: preload via 65536 accepted results. Required: done_cnt returns to 0x0000 after 0xFFFF.
